// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the converter and the FP add/sub wrappers.
// Combinational helpers only: no latency, no flow control.
package fpu_pkg;

    localparam int          FP32_EXP_W    = 8;
    localparam int          FP32_MANT_W   = 23;
    localparam int          FP32_BIAS     = 127;
    localparam logic [31:0] FP32_QNAN     = 32'h7FC00000;
    localparam logic [31:0] FP32_POS_ZERO = 32'h00000000;

    typedef struct packed {
        logic                   sign;
        logic [FP32_EXP_W-1:0]  exp;
        logic [FP32_MANT_W-1:0] mant;
    } fp32_t;

    function automatic fp32_t fp32_pack(
        input logic                   sign,
        input logic [FP32_EXP_W-1:0]  exp,
        input logic [FP32_MANT_W-1:0] mant
    );
        fp32_t f;
        f.sign = sign;
        f.exp  = exp;
        f.mant = mant;
        return f;
    endfunction

endpackage

// File: rtl/fx2fp_lod.sv
// Leading-one detector: index of the highest set bit plus a found flag.
// Purely combinational: zero latency, no flow control.
module fx2fp_lod #(
    parameter  int W  = 32,
    localparam int PW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  i_vec,
    output logic [PW-1:0] o_pos,
    output logic          o_found
);

    // Ascending scan so the last hit, the most significant one, wins.
    always_comb begin
        o_pos   = '0;
        o_found = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i_vec[i]) begin
                o_pos   = PW'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fixed_to_fp32.sv
// Signed fixed-point to FP32 converter, round-to-nearest-even; 3-cycle latency, 1 sample/cycle.
// Backpressure: one global enable (~o_valid | i_ready) freezes every stage; o_ready mirrors it.
module fixed_to_fp32
    import fpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_result,
    output logic              o_inexact
);

    localparam int NW    = (DATA_W > FP32_MANT_W + 2) ? DATA_W : FP32_MANT_W + 2;
    localparam int PW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PAD_W = NW - DATA_W;

    localparam logic [PW-1:0] MSB_IDX  = PW'(DATA_W - 1);
    // Bits below the guard position of the normalized field feed the sticky OR.
    localparam logic [NW-1:0] LOW_MASK = (NW'(1) << (NW - FP32_MANT_W - 2)) - NW'(1);

    if (DATA_W < 2 || DATA_W > 64 || FRAC_W > 126 || (DATA_W - 1 - FRAC_W) > 127) begin : g_param_check
        $error("fixed_to_fp32: DATA_W/FRAC_W out of range for a normal FP32 result");
    end

    logic en;

    logic              s1_vld_q;
    logic              s1_sign_q, s1_sign_d;
    logic              s1_zero_q, s1_zero_d;
    logic [DATA_W-1:0] s1_mag_q,  s1_mag_d;

    logic                   s2_vld_q;
    logic                   s2_sign_q;
    logic                   s2_zero_q;
    logic [PW-1:0]          s2_pos_q,    s2_pos_d;
    logic [FP32_MANT_W-1:0] s2_mant_q,   s2_mant_d;
    logic                   s2_guard_q,  s2_guard_d;
    logic                   s2_sticky_q, s2_sticky_d;

    logic  out_vld_q;
    fp32_t res_q,     res_d;
    logic  inexact_q, inexact_d;

    logic [PW-1:0]        lod_pos;
    logic                 lod_found;
    logic [PW-1:0]        norm_sh;
    logic [NW-1:0]        norm;
    logic                 round_up;
    logic [FP32_MANT_W:0] mant_sum;
    logic [7:0]           exp_d;

    assign en      = ~out_vld_q | i_ready;
    assign o_ready = en;

    // S1: sign/magnitude split; the most negative input maps to 2^(DATA_W-1) unsigned.
    always_comb begin
        s1_sign_d = i_data[DATA_W-1];
        s1_mag_d  = s1_sign_d ? (~i_data + DATA_W'(1)) : i_data;
        s1_zero_d = (s1_mag_d == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_mag_q  <= '0;
        end else if (en) begin
            s1_vld_q <= i_valid;
            if (i_valid) begin
                s1_sign_q <= s1_sign_d;
                s1_zero_q <= s1_zero_d;
                s1_mag_q  <= s1_mag_d;
            end
        end
    end

    // S2: normalize so the leading one lands on the MSB of the NW-bit field.
    fx2fp_lod #(
        .W (DATA_W)
    ) u_lod (
        .i_vec   (s1_mag_q),
        .o_pos   (lod_pos),
        .o_found (lod_found)
    );

    always_comb begin
        norm_sh     = MSB_IDX - lod_pos;
        norm        = lod_found ? ((NW'(s1_mag_q) << PAD_W) << norm_sh) : '0;
        s2_pos_d    = lod_pos;
        s2_mant_d   = norm[NW-2 -: FP32_MANT_W];
        s2_guard_d  = norm[NW-2-FP32_MANT_W];
        s2_sticky_d = |(norm & LOW_MASK);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_vld_q    <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_pos_q    <= '0;
            s2_mant_q   <= '0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
        end else if (en) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_sign_q   <= s1_sign_q;
                s2_zero_q   <= s1_zero_q;
                s2_pos_q    <= s2_pos_d;
                s2_mant_q   <= s2_mant_d;
                s2_guard_q  <= s2_guard_d;
                s2_sticky_q <= s2_sticky_d;
            end
        end
    end

    // S3: RNE round; a mantissa carry-out leaves all-zero fraction bits and bumps the exponent.
    always_comb begin
        round_up  = s2_guard_q & (s2_sticky_q | s2_mant_q[0]);
        mant_sum  = {1'b0, s2_mant_q} + (FP32_MANT_W + 1)'(round_up);
        exp_d     = 8'(FP32_BIAS - FRAC_W) + 8'(s2_pos_q) + 8'(mant_sum[FP32_MANT_W]);
        res_d     = s2_zero_q ? fp32_t'(FP32_POS_ZERO)
                              : fp32_pack(s2_sign_q, exp_d, mant_sum[FP32_MANT_W-1:0]);
        inexact_d = ~s2_zero_q & (s2_guard_q | s2_sticky_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_vld_q <= 1'b0;
            res_q     <= fp32_t'(FP32_POS_ZERO);
            inexact_q <= 1'b0;
        end else if (en) begin
            out_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                res_q     <= res_d;
                inexact_q <= inexact_d;
            end
        end
    end

    assign o_valid   = out_vld_q;
    assign o_result  = res_q;
    assign o_inexact = inexact_q;

endmodule

// File: tb/tb_fixed_to_fp32.sv
// Directed and randomized checks of fixed_to_fp32 at DATA_W=32, FRAC_W=16.
module tb_fixed_to_fp32;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_inexact;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] din;
        logic [31:0] dout;
        logic        inx;
    } vec_t;

    // Hand-computed: value = din / 2^16, FP32 round-to-nearest-even.
    vec_t dir_vecs [12] = '{
        '{32'h00010000, 32'h3F800000, 1'b0},   //  1.0
        '{32'hFFFF0000, 32'hBF800000, 1'b0},   // -1.0
        '{32'h00000000, 32'h00000000, 1'b0},   //  0.0
        '{32'h00008000, 32'h3F000000, 1'b0},   //  0.5
        '{32'hFFFFFFFF, 32'hB7800000, 1'b0},   // -2^-16
        '{32'h00000001, 32'h37800000, 1'b0},   //  2^-16
        '{32'h80000000, 32'hC7000000, 1'b0},   // -32768.0
        '{32'h7FFFFFFF, 32'h47000000, 1'b1},   // carry out -> exp 142
        '{32'h01000001, 32'h43800000, 1'b1},   // tie, even -> down
        '{32'h01000003, 32'h43800002, 1'b1},   // tie, odd -> up
        '{32'h01000005, 32'h43800002, 1'b1},   // tie, even -> down
        '{32'hFEFFFFFD, 32'hC3800002, 1'b1}    // negative tie, odd -> up
    };

    fixed_to_fp32 #(
        .DATA_W (32),
        .FRAC_W (16)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
        .o_inexact (o_inexact)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [32:0] ref_conv(input logic [31:0] d);
        logic [63:0] mag;
        logic [63:0] q;
        logic [63:0] rem;
        logic [63:0] half;
        logic [7:0]  e;
        logic        s;
        int          p;
        int          sh;
        s   = d[31];
        mag = s ? (64'h1_0000_0000 - {32'h0, d}) : {32'h0, d};
        if (mag == 64'd0) return 33'h0;
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        rem = 64'd0;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == 64'h100_0000) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        e = 8'(127 + p - 16);
        return {rem != 64'd0, s, e, q[22:0]};
    endfunction

    // Stimulus only: one sample, then report what emerged and after how many cycles.
    task automatic run_vec(input logic [31:0] d, output logic [31:0] res,
                           output logic inx, output int lat);
        @(posedge i_clk); #1;
        i_valid = 1'b1;
        i_data  = d;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_data  = '0;
        lat = -1;
        res = 'x;
        inx = 1'bx;
        for (int n = 1; n <= 8; n++) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) begin
                lat = n;
                res = o_result;
                inx = o_inexact;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_data  = '0;
        #12;
        vectors++;
        if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
        vectors++;
        if (o_result !== 32'h0) begin miscompares++; $display("FAIL reset_o_result got %h want 00000000", o_result); end
        vectors++;
        if (o_inexact !== 1'b0) begin miscompares++; $display("FAIL reset_o_inexact got %b want 0", o_inexact); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        vectors++;
        if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_o_ready got %b want 1", o_ready); end
    endtask

    task automatic test_basic_values();
        logic [31:0] res;
        logic        inx;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_vec(dir_vecs[i].din, res, inx, lat);
            vectors++;
            if (res !== dir_vecs[i].dout) begin
                miscompares++;
                $display("FAIL basic_result in=%h got %h want %h", dir_vecs[i].din, res, dir_vecs[i].dout);
            end
            vectors++;
            if (inx !== dir_vecs[i].inx) begin
                miscompares++;
                $display("FAIL basic_inexact in=%h got %b want %b", dir_vecs[i].din, inx, dir_vecs[i].inx);
            end
            vectors++;
            if (lat !== 3) begin
                miscompares++;
                $display("FAIL basic_latency in=%h got %0d want 3", dir_vecs[i].din, lat);
            end
        end
    endtask

    task automatic test_extremes_rounding();
        logic [31:0] res;
        logic        inx;
        int          lat;
        for (int i = 6; i < 12; i++) begin
            run_vec(dir_vecs[i].din, res, inx, lat);
            vectors++;
            if (res !== dir_vecs[i].dout) begin
                miscompares++;
                $display("FAIL round_result in=%h got %h want %h", dir_vecs[i].din, res, dir_vecs[i].dout);
            end
            vectors++;
            if (inx !== dir_vecs[i].inx) begin
                miscompares++;
                $display("FAIL round_inexact in=%h got %b want %b", dir_vecs[i].din, inx, dir_vecs[i].inx);
            end
            vectors++;
            if (lat !== 3) begin
                miscompares++;
                $display("FAIL round_latency in=%h got %0d want 3", dir_vecs[i].din, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] bp_in  [5];
        logic [31:0] bp_out [5];
        logic [31:0] held;
        logic        have_held;
        int          sent;
        int          got;
        bp_in[0] = 32'h00010000; bp_out[0] = 32'h3F800000;
        bp_in[1] = 32'hFFFF0000; bp_out[1] = 32'hBF800000;
        bp_in[2] = 32'h00008000; bp_out[2] = 32'h3F000000;
        bp_in[3] = 32'h80000000; bp_out[3] = 32'hC7000000;
        bp_in[4] = 32'h00000001; bp_out[4] = 32'h37800000;
        sent      = 0;
        got       = 0;
        held      = '0;
        have_held = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge i_clk); #1;
            i_valid = (sent < 5);
            i_data  = (sent < 5) ? bp_in[sent] : 32'h0;
            i_ready = !(c >= 2 && c < 8);
            @(negedge i_clk);
            if (o_valid && !i_ready) begin
                vectors++;
                if (o_ready !== 1'b0) begin miscompares++; $display("FAIL bp_o_ready cycle %0d got %b want 0", c, o_ready); end
                if (have_held) begin
                    vectors++;
                    if (o_result !== held) begin miscompares++; $display("FAIL bp_stall_hold cycle %0d got %h want %h", c, o_result, held); end
                end else begin
                    held      = o_result;
                    have_held = 1'b1;
                end
            end
            if (o_valid && i_ready) begin
                vectors++;
                if (got >= 5) begin
                    miscompares++;
                    $display("FAIL bp_extra_result got %h want none", o_result);
                end else if (o_result !== bp_out[got]) begin
                    miscompares++;
                    $display("FAIL bp_order idx %0d got %h want %h", got, o_result, bp_out[got]);
                end
                got++;
            end
            if (i_valid && o_ready) sent++;
        end
        i_valid = 1'b0;
        vectors++;
        if (!have_held) begin miscompares++; $display("FAIL bp_stall_seen got 0 want 1"); end
        vectors++;
        if (got !== 5) begin miscompares++; $display("FAIL bp_count got %0d want 5", got); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] res;
        logic        inx;
        int          lat;
        int          accepted;
        int          stale;
        accepted = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk); #1;
            i_valid = 1'b1;
            i_data  = 32'h00020000 + 32'(c);
            i_ready = 1'b0;
            @(negedge i_clk);
            if (i_valid && o_ready) accepted++;
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        vectors++;
        if (accepted !== 3 || o_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_inflight accepted %0d o_valid %b want 3 and 1", accepted, o_valid);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        vectors++;
        if (o_valid !== 1'b0) begin miscompares++; $display("FAIL rst_async_valid got %b want 0", o_valid); end
        vectors++;
        if (o_result !== 32'h0) begin miscompares++; $display("FAIL rst_async_result got %h want 00000000", o_result); end
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        stale   = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (o_valid !== 1'b0) stale++;
        end
        vectors++;
        if (stale !== 0) begin miscompares++; $display("FAIL rst_stale got %0d valid cycles want 0", stale); end
        run_vec(32'h00010000, res, inx, lat);
        vectors++;
        if (res !== 32'h3F800000 || inx !== 1'b0 || lat !== 3) begin
            miscompares++;
            $display("FAIL rst_next got %h/%b lat %0d want 3f800000/0 lat 3", res, inx, lat);
        end
    endtask

    task automatic test_soak();
        logic [32:0] exp_q [$];
        logic [32:0] e;
        logic [31:0] v;
        int          sent;
        int          got;
        int          n_samp;
        n_samp = 10000;
        sent   = 0;
        got    = 0;
        for (int cyc = 0; cyc < 60000 && got < n_samp; cyc++) begin
            @(posedge i_clk); #1;
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: begin
                    v = $urandom >> $urandom_range(0, 31);
                    if ($urandom_range(0, 1) == 1) v = -v;
                end
                2: case ($urandom_range(0, 4))
                       0: v = 32'h00000000;
                       1: v = 32'h80000000;
                       2: v = 32'h7FFFFFFF;
                       3: v = 32'hFFFFFFFF;
                       default: v = 32'h00000001;
                   endcase
                default: v = {$urandom_range(1, 255) << 24} | 32'($urandom_range(0, 7));
            endcase
            i_valid = (sent < n_samp) && ($urandom_range(0, 3) != 0);
            i_data  = v;
            i_ready = ($urandom_range(0, 3) != 0);
            @(negedge i_clk);
            if (o_valid && i_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL soak_unexpected got %h want none", o_result);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_inexact, o_result} !== e) begin
                        miscompares++;
                        $display("FAIL soak_result idx %0d got %b/%h want %b/%h", got, o_inexact, o_result, e[32], e[31:0]);
                    end
                end
                got++;
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(ref_conv(i_data));
                sent++;
            end
        end
        i_valid = 1'b0;
        vectors++;
        if (got !== n_samp) begin miscompares++; $display("FAIL soak_count got %0d want %0d", got, n_samp); end
    endtask

    initial begin
        test_reset();
        test_basic_values();
        test_extremes_rounding();
        test_backpressure();
        test_reset_midstream();
        test_soak();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
